regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file, successor to the single-write/dual-read RV32I file.
//  Serves up to NUM_RD asynchronous read ports and NUM_WR synchronous write ports.
//  Optionally forwards same-cycle write data to reads. Entry 0 can be hard-wired to zero.
//  Array is cleared by a sequential sweep FSM rather than a combinational reset loop.
//  Sits between decode (read) and writeback (write) in single-cycle and dual-issue cores.
// PARAMETERS
//  XLEN      32  data width of each register
//  NREGS     32  number of registers (power of two, >=2); AW = $clog2(NREGS)
//  NUM_RD    2   number of read ports (1..4)
//  NUM_WR    1   number of write ports (1..2)
//  ZERO_REG  1   1: entry 0 always reads 0, and writes to entry 0 are dropped
//  BYPASS    1   1: a read of an address being written this cycle returns the new data
// PORTS
//  clk       in   1            rising-edge clock
//  reset_n   in   1            synchronous active-low reset
//  clr_req   in   1            pulse: start a full-array clear sweep (ignored while clearing)
//  ready     out  1            1 = array valid; reads and writes honoured
//  ra        in   NUM_RD*AW    read addresses, port p at [p*AW +: AW]
//  rdata     out  NUM_RD*XLEN  read data, port p at [p*XLEN +: XLEN]
//  we        in   NUM_WR       per-port write enable
//  wa        in   NUM_WR*AW    write addresses
//  wdata     in   NUM_WR*XLEN  write data
// BEHAVIOUR
//  Reset: while reset_n=0 at a clk edge: state<=CLEAR, sweep index<=0, ready<=0.
//   rdata is forced to 0 while ready=0.
//  FSM states:
//   CLEAR: each cycle write 0 to entry idx, then idx<=idx+1.
//    When idx==NREGS-1, go to READY next cycle. The sweep takes exactly NREGS cycles.
//   READY: ready=1. clr_req=1 -> CLEAR with idx<=0 and ready<=0 on the next edge.
//    Any write in that same cycle is still performed, and the sweep later zeroes it.
//  The reset clause has priority over everything. reset_n=0 mid-sweep restarts the sweep at idx 0.
//  The sweep starts on the first edge after reset_n goes high.
//  Writes: committed at the rising clk edge when ready=1 and we[k]=1. All writes are ignored in CLEAR.
//   ZERO_REG=1 and wa[k]==0: the write is dropped.
//   Both ports write the same address: port NUM_WR-1 (highest index) wins.
//  Reads: combinational, zero latency.
//   rdata[p] = mem[ra[p]]. ZERO_REG=1 and ra[p]==0 -> 0.
//   BYPASS=1 and any port k has we[k]=1 and wa[k]==ra[p] with the write not dropped and ready=1:
//    rdata[p] = wdata[k], with the highest k winning.
//   BYPASS=0: the new value is visible the cycle after the write.
//  Widths: AW-bit addresses need no range check because NREGS=2^AW. The idx counter is AW bits.
//  No X may reach rdata after the first complete sweep.
// STRUCTURE
//  Shared package rv32i_pkg holds:
//   XLEN_DEF=32, REG_AW_DEF=5
//   rf_state_t {RF_CLEAR, RF_READY}
//   RF_ZERO = '0
//  Sub-module regfile_clr_fsm (clk, reset_n, clr_req -> clr_we, clr_idx, ready):
//   owns the state register and the sweep counter.
//  Top level holds the storage array, the write arbitration and the per-port read/bypass mux.
//  The sweep write is multiplexed onto the array write path; it is exclusive with port writes by construction.
// TESTING
//  1 Reset then release -> ready=0 for exactly 32 cycles, rises on cycle 32; all 32 entries read 0.
//  2 Write wa=5 wdata=32'hDEADBEEF, same cycle ra0=5:
//    BYPASS=1 -> rdata0=DEADBEEF that cycle; BYPASS=0 -> old value, then DEADBEEF next cycle.
//  3 Write wa=0 data=32'h1234 with ZERO_REG=1 -> ra=0 reads 0 in the same cycle and the next.
//    With ZERO_REG=0 -> reads 1234.
//  4 NUM_WR=2, both ports write addr 7 (port0=32'hAAAA, port1=32'h5555) -> entry 7 = 5555.
//    Bypass read of 7 shows 5555.
//  5 Preload entries, pulse clr_req along with a write to 9 -> ready low for 32 cycles.
//    Writes during the sweep are ignored; entry 9 reads 0 afterwards.
//  6 Drop reset_n for 1 cycle at sweep idx=20 -> ready stays 0 for a full 32 more cycles,
//    then all entries read 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared definitions for the integer register file family.
package rv32i_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam logic [XLEN_DEF-1:0] RF_ZERO = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/clear bundle between the pipeline and the multi-port register file.
interface regfile_mp_if
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned AW     = REG_AW_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1
);

  logic                   clr_req;
  logic                   ready;
  logic [NUM_RD*AW-1:0]   ra;
  logic [NUM_RD*XLEN-1:0] rdata;
  logic [NUM_WR-1:0]      we;
  logic [NUM_WR*AW-1:0]   wa;
  logic [NUM_WR*XLEN-1:0] wdata;

  modport master (output clr_req, ra, we, wa, wdata, input ready, rdata);
  modport slave  (input clr_req, ra, we, wa, wdata, output ready, rdata);

endinterface

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep controller: walks every entry once, then reports the array ready.
module regfile_clr_fsm
  import rv32i_pkg::*;
#(
  parameter  int unsigned NREGS = 32,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_req_i,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_idx_o,
  output logic          ready_o
);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RF_CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = RF_READY;
          idx_d   = '0;
        end
      end
      RF_READY: begin
        if (clr_req_i) begin
          state_d = RF_CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  assign clr_we_o  = (state_q == RF_CLEAR);
  assign clr_idx_o = idx_q;
  assign ready_o   = (state_q == RF_READY);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: async reads with optional bypass, sync writes, sweep clear.
module regfile_mp
  import rv32i_pkg::*;
#(
  parameter  int unsigned XLEN     = XLEN_DEF,
  parameter  int unsigned NREGS    = 32'(1) << REG_AW_DEF,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned NUM_WR   = 1,
  parameter  int unsigned ZERO_REG = 1,
  parameter  int unsigned BYPASS   = 1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_mp_if.slave  rf
);

  logic                   clr_we;
  logic [AW-1:0]          clr_idx;
  logic                   ready;
  logic [XLEN-1:0]        mem_q [NREGS];
  logic [AW-1:0]          wa_c  [NUM_WR];
  logic [XLEN-1:0]        wd_c  [NUM_WR];
  logic [NUM_WR-1:0]      wr_ok_c;
  logic [AW-1:0]          ra_c  [NUM_RD];
  logic [XLEN-1:0]        rv_c  [NUM_RD];
  logic [NUM_RD*XLEN-1:0] rdata_c;

  regfile_clr_fsm #(.NREGS(NREGS)) u_clr_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_req_i (rf.clr_req),
    .clr_we_o  (clr_we),
    .clr_idx_o (clr_idx),
    .ready_o   (ready)
  );

  // A port write is live only when the array is ready and the target is not a hard-wired zero.
  always_comb begin
    for (int k = 0; k < int'(NUM_WR); k++) begin
      wa_c[k]    = rf.wa[k*AW +: AW];
      wd_c[k]    = rf.wdata[k*XLEN +: XLEN];
      wr_ok_c[k] = ready && rf.we[k] && !((ZERO_REG != 0) && (wa_c[k] == '0));
    end
  end

  // Sweep and port writes never coincide; ascending port order lets the highest port win.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx] <= XLEN'(RF_ZERO);
    end else if (reset_n) begin
      for (int k = 0; k < int'(NUM_WR); k++) begin
        if (wr_ok_c[k]) mem_q[wa_c[k]] <= wd_c[k];
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      ra_c[p] = rf.ra[p*AW +: AW];
      rv_c[p] = mem_q[ra_c[p]];
      if ((ZERO_REG != 0) && (ra_c[p] == '0)) rv_c[p] = '0;
      if (BYPASS != 0) begin
        for (int k = 0; k < int'(NUM_WR); k++) begin
          if (wr_ok_c[k] && (wa_c[k] == ra_c[p])) rv_c[p] = wd_c[k];
        end
      end
      if (!ready) rv_c[p] = '0;
      rdata_c[p*XLEN +: XLEN] = rv_c[p];
    end
  end

  assign rf.rdata = rdata_c;
  assign rf.ready = ready;

endmodule
